// File: rtl/hpram_cmd_arbiter.sv
// hpram_cmd_arbiter: shares one HyperRAM command/data port between two DMA
// requesters (r0 = video frame buffer, r1 = auxiliary DMA).
// One command (one burst) is granted at a time. Grants alternate round-robin,
// and a turnaround gap is forced between commands. All traffic is held off
// until memory calibration completes.
// Ports:
//   iclk, irst           clock and synchronous active-high reset
//   iinit_calib          memory calibration done
//   ir*_req / or*_gnt    per-requester request and grant
//   ir*_cmd, _cmd_en, _addr, _wr_data, _data_mask   per-requester command side
//   or*_rd_data_valid, or*_rd_data, or*_done         per-requester return side
//   ocmd, ocmd_en, oaddr, owr_data, odata_mask       to the memory interface
//   ird_data_valid, ird_data                         from the memory interface
//   oerr                 sticky protocol/timeout error, cleared only by irst
module hpram_cmd_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 22,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MASK_WIDTH  = 4,
   parameter int unsigned BURST_BEATS = 4,
   parameter int unsigned TURNAROUND  = 2,
   parameter int unsigned RD_TIMEOUT  = 255
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic                  iinit_calib,
   input  logic                  ir0_req,
   input  logic                  ir1_req,
   output logic                  or0_gnt,
   output logic                  or1_gnt,
   input  logic                  ir0_cmd,
   input  logic                  ir1_cmd,
   input  logic                  ir0_cmd_en,
   input  logic                  ir1_cmd_en,
   input  logic [ADDR_WIDTH-1:0] ir0_addr,
   input  logic [ADDR_WIDTH-1:0] ir1_addr,
   input  logic [DATA_WIDTH-1:0] ir0_wr_data,
   input  logic [DATA_WIDTH-1:0] ir1_wr_data,
   input  logic [MASK_WIDTH-1:0] ir0_data_mask,
   input  logic [MASK_WIDTH-1:0] ir1_data_mask,
   output logic                  or0_rd_data_valid,
   output logic                  or1_rd_data_valid,
   output logic [DATA_WIDTH-1:0] or0_rd_data,
   output logic [DATA_WIDTH-1:0] or1_rd_data,
   output logic                  or0_done,
   output logic                  or1_done,
   output logic                  ocmd,
   output logic                  ocmd_en,
   output logic [ADDR_WIDTH-1:0] oaddr,
   output logic [DATA_WIDTH-1:0] owr_data,
   output logic [MASK_WIDTH-1:0] odata_mask,
   input  logic                  ird_data_valid,
   input  logic [DATA_WIDTH-1:0] ird_data,
   output logic                  oerr
);

   localparam int unsigned BEAT_W = $clog2(BURST_BEATS + 1);
   localparam int unsigned TO_W   = $clog2(RD_TIMEOUT + 1);
   localparam int unsigned TA_W   = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WR, S_RD, S_REL} state_t;

   state_t            state, state_next;
   logic              owner, owner_next;     // 0 = r0, 1 = r1
   logic              prefer, prefer_next;   // rr-preferred requester
   logic [BEAT_W-1:0] beat_cnt, beat_next, beat_sum;
   logic [TO_W-1:0]   to_cnt, to_next, to_sum;
   logic [TA_W-1:0]   ta_cnt, ta_next;
   logic              timeout_hit;
   logic              err, err_proto;

   // Owner-selected request-side signals
   logic                  own_req, own_cmd, own_cmd_en;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_wr_data;
   logic [MASK_WIDTH-1:0] own_mask;

   assign own_req     = owner ? ir1_req       : ir0_req;
   assign own_cmd     = owner ? ir1_cmd       : ir0_cmd;
   assign own_cmd_en  = owner ? ir1_cmd_en    : ir0_cmd_en;
   assign own_addr    = owner ? ir1_addr      : ir0_addr;
   assign own_wr_data = owner ? ir1_wr_data   : ir0_wr_data;
   assign own_mask    = owner ? ir1_data_mask : ir0_data_mask;

   // cmd_en is legal only from the owner while waiting in GRANT; read beats only in RD
   assign err_proto = (ir0_cmd_en & ~((state == S_GRANT) & ~owner))
                    | (ir1_cmd_en & ~((state == S_GRANT) &  owner))
                    | (ird_data_valid & (state != S_RD));

   // State and counter registers
   always_ff @(posedge iclk) begin
      if (irst) begin
         state    <= S_IDLE;
         owner    <= 1'b0;
         prefer   <= 1'b0;
         beat_cnt <= '0;
         to_cnt   <= '0;
         ta_cnt   <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_next;
         owner    <= owner_next;
         prefer   <= prefer_next;
         beat_cnt <= beat_next;
         to_cnt   <= to_next;
         ta_cnt   <= ta_next;
         err      <= err | err_proto | timeout_hit;
      end
   end

   // Next-state and counter updates
   always_comb begin
      state_next  = state;
      owner_next  = owner;
      prefer_next = prefer;
      beat_next   = beat_cnt;
      to_next     = to_cnt;
      ta_next     = ta_cnt;
      beat_sum    = beat_cnt + BEAT_W'(ird_data_valid);
      to_sum      = to_cnt + TO_W'(1);
      timeout_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (ta_cnt != '0) begin
               ta_next = ta_cnt - TA_W'(1);
            end else if (ir0_req | ir1_req) begin
               owner_next = ir1_req & (~ir0_req | prefer);
               state_next = S_GRANT;
            end
         end
         S_GRANT: begin
            // The cmd_en cycle itself carries write beat 0
            if (own_cmd_en) begin
               beat_next  = own_cmd ? BEAT_W'(1) : '0;
               to_next    = '0;
               state_next = own_cmd ? S_WR : S_RD;
            end else if (!own_req) begin
               state_next = S_IDLE;
            end
         end
         S_WR: begin
            if (beat_cnt == BEAT_W'(BURST_BEATS - 1)) begin
               state_next = S_REL;
            end else begin
               beat_next = beat_cnt + BEAT_W'(1);
            end
         end
         S_RD: begin
            beat_next = beat_sum;
            to_next   = to_sum;
            if (beat_sum == BEAT_W'(BURST_BEATS)) begin
               state_next = S_REL;
            end else if (to_sum == TO_W'(RD_TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_next  = S_REL;
            end
         end
         S_REL: begin
            prefer_next = ~owner;
            ta_next     = TA_W'(TURNAROUND);
            state_next  = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      // Losing calibration aborts whatever is in flight
      if (!iinit_calib) begin
         state_next = S_IDLE;
         beat_next  = '0;
         to_next    = '0;
         ta_next    = '0;
      end
   end

   // Output decode: memory side is a zero-latency mux of the granted requester
   always_comb begin
      logic granted, in_rd, in_rel;
      granted           = (state == S_GRANT) | (state == S_WR) | (state == S_RD);
      in_rd             = (state == S_RD);
      in_rel            = (state == S_REL);
      or0_gnt           = granted & ~owner;
      or1_gnt           = granted &  owner;
      or0_done          = in_rel & ~owner;
      or1_done          = in_rel &  owner;
      ocmd_en           = (state == S_GRANT) & own_cmd_en;
      ocmd              = granted & own_cmd;
      oaddr             = granted ? own_addr    : '0;
      owr_data          = granted ? own_wr_data : '0;
      odata_mask        = granted ? own_mask    : '0;
      or0_rd_data_valid = in_rd & ~owner & ird_data_valid;
      or1_rd_data_valid = in_rd &  owner & ird_data_valid;
      or0_rd_data       = in_rd ? ird_data : '0;
      or1_rd_data       = in_rd ? ird_data : '0;
      oerr              = err;
   end

endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Directed self-checking bench for hpram_cmd_arbiter: calibration gate,
// write burst, round-robin reads, read timeout, protocol error and aborts.
module tb_hpram_cmd_arbiter;

   logic        iclk = 1'b0;
   logic        irst, iinit_calib;
   logic        ir0_req, ir1_req, ir0_cmd, ir1_cmd, ir0_cmd_en, ir1_cmd_en;
   logic [21:0] ir0_addr, ir1_addr, oaddr;
   logic [31:0] ir0_wr_data, ir1_wr_data, or0_rd_data, or1_rd_data, owr_data, ird_data;
   logic [3:0]  ir0_data_mask, ir1_data_mask, odata_mask;
   logic        or0_gnt, or1_gnt, or0_rd_data_valid, or1_rd_data_valid, or0_done, or1_done;
   logic        ocmd, ocmd_en, ird_data_valid, oerr;

   int n_chk  = 0;
   int n_fail = 0;

   hpram_cmd_arbiter dut (
      .iclk(iclk), .irst(irst), .iinit_calib(iinit_calib),
      .ir0_req(ir0_req), .ir1_req(ir1_req), .or0_gnt(or0_gnt), .or1_gnt(or1_gnt),
      .ir0_cmd(ir0_cmd), .ir1_cmd(ir1_cmd), .ir0_cmd_en(ir0_cmd_en), .ir1_cmd_en(ir1_cmd_en),
      .ir0_addr(ir0_addr), .ir1_addr(ir1_addr),
      .ir0_wr_data(ir0_wr_data), .ir1_wr_data(ir1_wr_data),
      .ir0_data_mask(ir0_data_mask), .ir1_data_mask(ir1_data_mask),
      .or0_rd_data_valid(or0_rd_data_valid), .or1_rd_data_valid(or1_rd_data_valid),
      .or0_rd_data(or0_rd_data), .or1_rd_data(or1_rd_data),
      .or0_done(or0_done), .or1_done(or1_done),
      .ocmd(ocmd), .ocmd_en(ocmd_en), .oaddr(oaddr), .owr_data(owr_data),
      .odata_mask(odata_mask), .ird_data_valid(ird_data_valid), .ird_data(ird_data),
      .oerr(oerr)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven 2 ns after the edge, outputs checked 1 ns later
   task automatic cyc();
      @(posedge iclk);
      #2;
   endtask

   task automatic drive_cmd(input bit who, input logic en, input logic cmd,
                            input logic [21:0] addr, input logic [31:0] wd);
      if (who) begin
         ir1_cmd_en = en; ir1_cmd = cmd; ir1_addr = addr; ir1_wr_data = wd; ir1_data_mask = 4'hF;
      end else begin
         ir0_cmd_en = en; ir0_cmd = cmd; ir0_addr = addr; ir0_wr_data = wd; ir0_data_mask = 4'hF;
      end
   endtask

   task automatic wait_gnt(input string tag, output bit who);
      for (int i = 0; i < 20; i++) begin
         if (or0_gnt | or1_gnt) break;
         cyc();
         #1;
      end
      chk(tag, 64'(or0_gnt | or1_gnt), 64'd1);
      who = or1_gnt;
   endtask

   // Write burst from the owner in GRANT; optionally pulse the other requester's cmd_en
   task automatic wr_burst(input bit who, input logic [21:0] addr, input logic [31:0] base,
                           input bit inject);
      drive_cmd(who, 1'b1, 1'b1, addr, base);
      #1;
      chk("wr_cmd_en", 64'(ocmd_en), 64'd1);
      chk("wr_cmd", 64'(ocmd), 64'd1);
      chk("wr_addr", 64'(oaddr), 64'(addr));
      chk("wr_beat0", 64'(owr_data), 64'(base));
      for (int b = 1; b < 4; b++) begin
         cyc();
         drive_cmd(who, 1'b0, 1'b1, addr, base + 32'(b));
         drive_cmd(!who, inject && b == 1, 1'b1, 22'h3FFFFF, 32'hDEAD);
         #1;
         chk("wr_no_cmd_en", 64'(ocmd_en), 64'd0);
         chk("wr_beat", 64'(owr_data), 64'(base + 32'(b)));
         chk("wr_gnt", 64'(who ? or1_gnt : or0_gnt), 64'd1);
      end
      cyc();
      drive_cmd(!who, 1'b0, 1'b0, '0, '0);
      #1;
      chk("wr_done", 64'(who ? or1_done : or0_done), 64'd1);
      chk("wr_gnt_off", 64'(or0_gnt | or1_gnt), 64'd0);
   endtask

   // Read burst from the owner in GRANT with four valid beats
   task automatic rd_burst(input bit who, input logic [21:0] addr, input logic [31:0] base);
      drive_cmd(who, 1'b1, 1'b0, addr, '0);
      #1;
      chk("rd_cmd_en", 64'(ocmd_en), 64'd1);
      chk("rd_cmd", 64'(ocmd), 64'd0);
      chk("rd_addr", 64'(oaddr), 64'(addr));
      for (int b = 0; b < 4; b++) begin
         cyc();
         drive_cmd(who, 1'b0, 1'b0, addr, '0);
         ird_data_valid = 1'b1;
         ird_data       = base + 32'(b);
         #1;
         chk("rd_own_vld", 64'(who ? or1_rd_data_valid : or0_rd_data_valid), 64'd1);
         chk("rd_other_vld", 64'(who ? or0_rd_data_valid : or1_rd_data_valid), 64'd0);
         chk("rd_data", 64'(who ? or1_rd_data : or0_rd_data), 64'(base + 32'(b)));
      end
      cyc();
      ird_data_valid = 1'b0;
      ird_data       = '0;
      #1;
      chk("rd_done", 64'(who ? or1_done : or0_done), 64'd1);
      chk("rd_gnt_off", 64'(or0_gnt | or1_gnt), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      bit who;
      int n;
      logic seen;
      irst = 1'b1; iinit_calib = 1'b0; ir0_req = 1'b0; ir1_req = 1'b0;
      ird_data_valid = 1'b0; ird_data = '0;
      drive_cmd(1'b0, 1'b0, 1'b0, '0, '0);
      drive_cmd(1'b1, 1'b0, 1'b0, '0, '0);
      cyc(); cyc();
      #1;
      chk("rst_gnt", 64'({or0_gnt, or1_gnt}), 64'd0);
      chk("rst_cmd_en", 64'(ocmd_en), 64'd0);
      chk("rst_addr", 64'(oaddr), 64'd0);
      chk("rst_err", 64'(oerr), 64'd0);
      chk("rst_done", 64'({or0_done, or1_done}), 64'd0);
      irst = 1'b0;

      // Calibration gate
      ir0_req = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         #1;
         seen = seen | or0_gnt;
      end
      chk("cal_gate", 64'(seen), 64'd0);
      iinit_calib = 1'b1;
      cyc(); cyc();
      #1;
      chk("cal_gnt", 64'(or0_gnt), 64'd1);

      // Single write, then turnaround gap to the next grant (r1)
      wr_burst(1'b0, 22'h000100, 32'hA0, 1'b0);
      ir0_req = 1'b0;
      ir1_req = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n++;
         #1;
         if (n == 1) chk("done_one_cycle", 64'(or0_done), 64'd0);
         if (or1_gnt) break;
      end
      chk("turnaround", 64'(n), 64'd4);
      chk("wr_no_err", 64'(oerr), 64'd0);

      // r1 read moves the rr pointer to r0
      rd_burst(1'b1, 22'h000200, 32'h1000);

      // Round-robin with both requesting continuously
      ir0_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_gnt("rr_gnt", who);
         chk("rr_order", 64'(who), 64'(k % 2));
         rd_burst(who, 22'(k), 32'h2000 + 32'(k * 16));
      end
      ir0_req = 1'b0;
      ir1_req = 1'b0;

      // Read timeout on r1 with only two beats returned
      ir1_req = 1'b1;
      wait_gnt("to_gnt", who);
      chk("to_owner", 64'(who), 64'd1);
      drive_cmd(1'b1, 1'b1, 1'b0, 22'h000300, '0);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         cyc();
         n++;
         drive_cmd(1'b1, 1'b0, 1'b0, 22'h000300, '0);
         ird_data_valid = (n <= 2);
         ird_data       = 32'h3000 + 32'(n);
         #1;
         if (or1_done) break;
      end
      ird_data_valid = 1'b0;
      chk("to_cycles", 64'(n), 64'd256);
      chk("to_err", 64'(oerr), 64'd1);
      ir1_req = 1'b0;
      ir0_req = 1'b1;
      wait_gnt("after_to_gnt", who);
      chk("after_to_owner", 64'(who), 64'd0);
      rd_burst(1'b0, 22'h000400, 32'h4000);

      // Reset clears the sticky error
      irst = 1'b1;
      cyc();
      irst = 1'b0;
      #1;
      chk("rst_clr_err", 64'(oerr), 64'd0);

      // Protocol error: r1 cmd_en while r0 owns the port
      wait_gnt("pe_gnt", who);
      chk("pe_owner", 64'(who), 64'd0);
      wr_burst(1'b0, 22'h000500, 32'hB0, 1'b1);
      chk("pe_err", 64'(oerr), 64'd1);

      // Calibration lost at write beat 2
      wait_gnt("ab_gnt", who);
      drive_cmd(1'b0, 1'b1, 1'b1, 22'h000600, 32'hC0);
      cyc();
      drive_cmd(1'b0, 1'b0, 1'b1, 22'h000600, 32'hC1);
      cyc();
      drive_cmd(1'b0, 1'b0, 1'b1, 22'h000600, 32'hC2);
      iinit_calib = 1'b0;
      cyc();
      #1;
      chk("ab_gnt_off", 64'(or0_gnt), 64'd0);
      chk("ab_cmd", 64'(ocmd), 64'd0);
      chk("ab_wdata", 64'(owr_data), 64'd0);
      chk("ab_done", 64'(or0_done), 64'd0);
      cyc();
      #1;
      chk("ab_done_late", 64'(or0_done), 64'd0);

      // Reset in the middle of a read
      iinit_calib = 1'b1;
      wait_gnt("rr_rst_gnt", who);
      drive_cmd(1'b0, 1'b1, 1'b0, 22'h000700, '0);
      cyc();
      drive_cmd(1'b0, 1'b0, 1'b0, 22'h000700, '0);
      ird_data_valid = 1'b1;
      ird_data       = 32'h5555;
      #1;
      chk("mid_rd_vld", 64'(or0_rd_data_valid), 64'd1);
      chk("mid_rd_err", 64'(oerr), 64'd1);
      cyc();
      irst = 1'b1;
      ird_data_valid = 1'b0;
      cyc();
      #1;
      chk("rrst_gnt", 64'({or0_gnt, or1_gnt}), 64'd0);
      chk("rrst_addr", 64'(oaddr), 64'd0);
      chk("rrst_rdata", 64'(or0_rd_data), 64'd0);
      chk("rrst_done", 64'({or0_done, or1_done}), 64'd0);
      chk("rrst_err", 64'(oerr), 64'd0);
      irst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
